edge_detect_bank: RTL and testbench

Multi-channel, parametrised edge detector. It is the next generation of the single-channel rising-edge cell.
- Each channel synchronises an asynchronous input and detects rising, falling or both edges, selected by a run-time mode.
- Each channel produces a one-cycle pulse, a sticky flag and a saturating event counter.
- Sits between raw pad inputs and user logic in TinyTapeout-style designs; counters are read back through a channel-select mux.

---
 rtl/edge_detect_bank_if.sv | 26 ++
 rtl/edge_detect_bank.sv | 118 +++++++++++
 tb/tb_edge_detect_bank.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_detect_bank_if.sv
// Channel bus for edge_detect_bank: raw inputs and controls in, pulses, flags and counter readback out.
// master drives din/mode/clr/cnt_sel; slave (the detector bank) drives the results.
interface edge_detect_bank_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic [N_CH-1:0]  din;
    logic [1:0]       mode;
    logic             clr;
    logic [SEL_W-1:0] cnt_sel;
    logic [N_CH-1:0]  pulse_o;
    logic [N_CH-1:0]  sticky_o;
    logic             any_o;
    logic [CNT_W-1:0] cnt_o;

    modport master (
        output din, mode, clr, cnt_sel,
        input  pulse_o, sticky_o, any_o, cnt_o
    );

    modport slave (
        input  din, mode, clr, cnt_sel,
        output pulse_o, sticky_o, any_o, cnt_o
    );
endinterface

// File: rtl/edge_detect_bank.sv
// Multi-channel synchronising edge detector with one-cycle pulses, sticky flags and saturating counters.
// Latency: din change before edge k -> pulse_o after edge k+SYNC_STAGES+1. No backpressure; events are never stalled.
module edge_detect_bank #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input logic               clk,
    input logic               rst_n,
    edge_detect_bank_if.slave bus
);
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int WU_MAX = SYNC_STAGES + 1;
    localparam int WU_W   = $clog2(WU_MAX + 1);
    localparam logic [WU_W-1:0] WU_DONE = WU_W'(WU_MAX);

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync;
    logic [N_CH-1:0]                  s;
    logic [N_CH-1:0]                  prev;
    logic [N_CH-1:0]                  rise_q;
    logic [N_CH-1:0]                  fall_q;
    logic [N_CH-1:0]                  ev;
    logic [N_CH-1:0]                  pulse;
    logic [N_CH-1:0]                  sticky;
    logic                             any;
    logic [N_CH-1:0][CNT_W-1:0]       cnt;
    logic [WU_W-1:0]                  wu;
    logic                             warm;
    logic                             mode_off;

    assign s        = sync[SYNC_STAGES-1];
    assign warm     = (wu == WU_DONE);
    assign mode_off = (bus.mode == 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= '0;
            wu   <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.din};
            prev <= s;
            if (!warm) begin
                wu <= wu + 1'b1;
            end
        end
    end

    // Edge terms are masked while warming up so inputs already high at release
    // never look like a rising edge; mode 11 drops them so re-enabling is clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else if (!warm || mode_off) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= s & ~prev;
            fall_q <= ~s & prev;
        end
    end

    always_comb begin
        ev = '0;
        case (bus.mode)
            2'b00:   ev = rise_q;
            2'b01:   ev = fall_q;
            2'b10:   ev = rise_q | fall_q;
            default: ev = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse <= '0;
            any   <= 1'b0;
        end else begin
            pulse <= ev;
            any   <= |ev;
        end
    end

    // An event on the same edge as clr wins: that channel restarts at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= '0;
            cnt    <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ev[i]) begin
                    sticky[i] <= 1'b1;
                    if (bus.clr) begin
                        cnt[i] <= CNT_W'(1);
                    end else if (cnt[i] != {CNT_W{1'b1}}) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else if (bus.clr) begin
                    sticky[i] <= 1'b0;
                    cnt[i]    <= '0;
                end
            end
        end
    end

    always_comb begin
        bus.cnt_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.cnt_sel == SEL_W'(i)) begin
                bus.cnt_o = cnt[i];
            end
        end
    end

    assign bus.pulse_o  = pulse;
    assign bus.sticky_o = sticky;
    assign bus.any_o    = any;
endmodule

// File: tb/tb_edge_detect_bank.sv
// Directed bench for edge_detect_bank: default instance plus a 4-bit-counter instance for saturation.
module tb_edge_detect_bank;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    edge_detect_bank_if #(.N_CH(4), .CNT_W(8)) bus_a ();
    edge_detect_bank_if #(.N_CH(4), .CNT_W(4)) bus_b ();

    edge_detect_bank #(.N_CH(4), .SYNC_STAGES(2), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    edge_detect_bank #(.N_CH(4), .SYNC_STAGES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_a;
        bus_a.clr = 1'b1;
        tick();
        bus_a.clr = 1'b0;
    endtask

    task automatic test_reset;
        int bad;
        rst_n = 1'b0;
        bus_a.din = 4'hF; bus_a.mode = 2'b00; bus_a.clr = 1'b0; bus_a.cnt_sel = 2'd0;
        bus_b.din = 4'h0; bus_b.mode = 2'b00; bus_b.clr = 1'b0; bus_b.cnt_sel = 2'd0;
        #2;
        checks++;
        if ({bus_a.pulse_o, bus_a.sticky_o, bus_a.any_o, bus_a.cnt_o} !== 17'd0) begin
            failures++;
            $display("FAIL reset_state: got pulse=%b sticky=%b any=%b cnt=%0d, want all 0",
                     bus_a.pulse_o, bus_a.sticky_o, bus_a.any_o, bus_a.cnt_o);
        end
        tick(); tick();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus_a.pulse_o !== 4'd0 || bus_a.sticky_o !== 4'd0 || bus_a.any_o !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_warmup: %0d cycles with pulse/sticky/any set, want 0", bad);
        end
        for (int i = 0; i < 4; i++) begin
            bus_a.cnt_sel = 2'(i);
            #1;
            checks++;
            if (bus_a.cnt_o !== 8'd0) begin
                failures++;
                $display("FAIL reset_cnt%0d: got %0d want 0", i, bus_a.cnt_o);
            end
        end
        bus_a.cnt_sel = 2'd0;
    endtask

    task automatic test_latency;
        bus_a.din = 4'h0;
        repeat (6) tick();
        clr_a();
        bus_a.din = 4'b0001;
        tick(); tick(); tick();
        checks++;
        if (bus_a.pulse_o !== 4'b0000) begin
            failures++;
            $display("FAIL latency_early: pulse=%b want 0000 after edge k+2", bus_a.pulse_o);
        end
        tick();
        checks++;
        if (bus_a.pulse_o !== 4'b0001 || bus_a.any_o !== 1'b1) begin
            failures++;
            $display("FAIL latency_pulse: pulse=%b any=%b want 0001/1", bus_a.pulse_o, bus_a.any_o);
        end
        checks++;
        if (bus_a.cnt_o !== 8'd1 || bus_a.sticky_o !== 4'b0001) begin
            failures++;
            $display("FAIL latency_cnt: cnt=%0d sticky=%b want 1/0001", bus_a.cnt_o, bus_a.sticky_o);
        end
        tick();
        checks++;
        if (bus_a.pulse_o !== 4'b0000 || bus_a.any_o !== 1'b0) begin
            failures++;
            $display("FAIL latency_single: pulse=%b any=%b want 0000/0", bus_a.pulse_o, bus_a.any_o);
        end
    endtask

    task automatic test_modes;
        int pcount;
        int anybad;
        bus_a.cnt_sel = 2'd2;
        bus_a.mode    = 2'b10;
        pcount = 0; anybad = 0;
        for (int c = 0; c < 68; c++) begin
            if (c < 64) bus_a.din[2] = ((c % 8) < 4);
            tick();
            if (bus_a.pulse_o[2] === 1'b1) pcount++;
            if (bus_a.any_o !== bus_a.pulse_o[2]) anybad++;
        end
        checks++;
        if (pcount !== 16 || anybad !== 0) begin
            failures++;
            $display("FAIL both_pulses: got %0d pulses (%0d any_o mismatches) want 16 (0)", pcount, anybad);
        end
        checks++;
        if (bus_a.cnt_o !== 8'd16) begin
            failures++;
            $display("FAIL both_cnt: got %0d want 16", bus_a.cnt_o);
        end
        bus_a.mode = 2'b01;
        pcount = 0;
        for (int c = 0; c < 68; c++) begin
            if (c < 64) bus_a.din[2] = ((c % 8) < 4);
            tick();
            if (bus_a.pulse_o[2] === 1'b1) pcount++;
        end
        checks++;
        if (pcount !== 8 || bus_a.cnt_o !== 8'd24) begin
            failures++;
            $display("FAIL fall_cnt: got %0d pulses cnt=%0d want 8 pulses cnt=24", pcount, bus_a.cnt_o);
        end
    endtask

    task automatic test_saturation;
        bus_b.cnt_sel = 2'd1;
        for (int e = 0; e < 20; e++) begin
            bus_b.din[1] = 1'b1;
            bus_b.din[3] = (e < 3);
            tick(); tick();
            bus_b.din[1] = 1'b0;
            bus_b.din[3] = 1'b0;
            tick(); tick();
        end
        repeat (4) tick();
        checks++;
        if (bus_b.cnt_o !== 4'd15 || bus_b.sticky_o !== 4'b1010) begin
            failures++;
            $display("FAIL sat_cnt: cnt=%0d sticky=%b want 15/1010", bus_b.cnt_o, bus_b.sticky_o);
        end
        bus_b.cnt_sel = 2'd3;
        #1;
        checks++;
        if (bus_b.cnt_o !== 4'd3) begin
            failures++;
            $display("FAIL sat_ch3: got %0d want 3", bus_b.cnt_o);
        end
        bus_b.din[1] = 1'b1;
        tick(); tick(); tick();
        bus_b.clr = 1'b1;
        tick();
        bus_b.clr = 1'b0;
        bus_b.cnt_sel = 2'd1;
        #1;
        checks++;
        if (bus_b.pulse_o[1] !== 1'b1 || bus_b.cnt_o !== 4'd1 || bus_b.sticky_o !== 4'b0010) begin
            failures++;
            $display("FAIL clr_collide: pulse1=%b cnt=%0d sticky=%b want 1/1/0010",
                     bus_b.pulse_o[1], bus_b.cnt_o, bus_b.sticky_o);
        end
        bus_b.cnt_sel = 2'd3;
        #1;
        checks++;
        if (bus_b.cnt_o !== 4'd0) begin
            failures++;
            $display("FAIL clr_ch3: got %0d want 0", bus_b.cnt_o);
        end
    endtask

    task automatic test_disable;
        int bad;
        int pcount;
        bus_a.mode = 2'b11;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            bus_a.din = (c < 3 || c >= 6) ? 4'hF : 4'h0;
            tick();
            if (bus_a.pulse_o !== 4'd0 || bus_a.any_o !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL disable_pulse: %0d cycles with pulse/any set, want 0", bad);
        end
        bus_a.cnt_sel = 2'd0; #1;
        checks++;
        if (bus_a.cnt_o !== 8'd1) begin
            failures++;
            $display("FAIL disable_cnt0: got %0d want 1", bus_a.cnt_o);
        end
        bus_a.cnt_sel = 2'd2; #1;
        checks++;
        if (bus_a.cnt_o !== 8'd24 || bus_a.sticky_o !== 4'b0101) begin
            failures++;
            $display("FAIL disable_cnt2: cnt=%0d sticky=%b want 24/0101", bus_a.cnt_o, bus_a.sticky_o);
        end
        bus_a.mode = 2'b00;
        pcount = 0;
        repeat (10) begin
            tick();
            if (bus_a.pulse_o !== 4'd0) pcount++;
        end
        checks++;
        if (pcount !== 0) begin
            failures++;
            $display("FAIL reenable_stale: %0d pulses want 0", pcount);
        end
        bus_a.din[3] = 1'b0;
        repeat (5) tick();
        bus_a.din[3] = 1'b1;
        pcount = 0;
        repeat (8) begin
            tick();
            if (bus_a.pulse_o[3] === 1'b1) pcount++;
        end
        bus_a.cnt_sel = 2'd3; #1;
        checks++;
        if (pcount !== 1 || bus_a.cnt_o !== 8'd1) begin
            failures++;
            $display("FAIL reenable_edge: %0d pulses cnt=%0d want 1/1", pcount, bus_a.cnt_o);
        end
    endtask

    task automatic test_reset_midstream;
        int bad;
        bus_a.mode = 2'b00;
        bus_a.cnt_sel = 2'd0;
        bus_a.din = 4'h0;
        repeat (4) tick();
        clr_a();
        for (int e = 0; e < 4; e++) begin
            bus_a.din[0] = 1'b1;
            tick(); tick();
            bus_a.din[0] = 1'b0;
            tick(); tick();
        end
        bus_a.din[0] = 1'b1;
        repeat (4) tick();
        checks++;
        if (bus_a.pulse_o[0] !== 1'b1 || bus_a.cnt_o !== 8'd5) begin
            failures++;
            $display("FAIL pre_reset: pulse0=%b cnt=%0d want 1/5", bus_a.pulse_o[0], bus_a.cnt_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.pulse_o, bus_a.sticky_o, bus_a.any_o, bus_a.cnt_o} !== 17'd0) begin
            failures++;
            $display("FAIL async_reset: pulse=%b sticky=%b any=%b cnt=%0d want all 0",
                     bus_a.pulse_o, bus_a.sticky_o, bus_a.any_o, bus_a.cnt_o);
        end
        tick(); tick();
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (bus_a.pulse_o !== 4'd0 || bus_a.sticky_o !== 4'd0) bad++;
        end
        checks++;
        if (bad !== 0 || bus_a.cnt_o !== 8'd0) begin
            failures++;
            $display("FAIL rewarmup: %0d bad cycles cnt=%0d want 0/0", bad, bus_a.cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_modes();
        test_saturation();
        test_disable();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
